// File: rtl/rle_vga_pkg.sv
// Shared types and flash command opcodes for the QSPI stream controller.
package rle_vga_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST_EN,
    RST,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    STALL
  } state_e;

  localparam logic [7:0] CMD_QUAD_READ = 8'h6B;
  localparam logic [7:0] CMD_RST_EN    = 8'h66;
  localparam logic [7:0] CMD_RST       = 8'h99;

  // CS-high cycles between the two flash reset commands
  localparam logic [1:0] FLASH_RST_GAP = 2'd2;

endpackage

// File: rtl/word_fifo2.sv
// Two-entry output FIFO with registered head word and synchronous clear.
module word_fifo2
  import rle_vga_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [WORD_W-1:0] din,
  input  logic              pop,
  output logic [WORD_W-1:0] dout,
  output logic              valid,
  output logic [1:0]        count
);

  logic [WORD_W-1:0] mem0_q, mem0_d;
  logic [WORD_W-1:0] mem1_q, mem1_d;
  logic [1:0]        count_q, count_d;
  logic              pop_en, push_en;

  always_comb begin
    pop_en  = pop && (count_q != 2'd0);
    push_en = push && ((count_q != 2'd2) || pop_en);
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    count_d = count_q;
    if (clr) begin
      count_d = 2'd0;
    end else begin
      case ({push_en, pop_en})
        2'b10: begin
          if (count_q == 2'd0) mem0_d = din;
          else                 mem1_d = din;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          mem0_d  = mem1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            mem0_d = din;
          end else begin
            mem0_d = mem1_q;
            mem1_d = din;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem0_q  <= '0;
      mem1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
      count_q <= count_d;
    end
  end

  assign dout  = mem0_q;
  assign valid = count_q != 2'd0;
  assign count = count_q;

endmodule

// File: rtl/qspi_stream_ctrl.sv
// Quad-output SPI flash reader streaming packed nibbles to the RLE decoder.
// Define QSPI_STREAM_CTRL_FLASH_RESET_EN to send 0x66/0x99 to the flash after rst.
module qspi_stream_ctrl
  import rle_vga_pkg::*;
#(
  parameter int ADDR_W    = 24,
  parameter int DUMMY_SCK = 8,
  parameter int WORD_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              stop,
  output logic              busy,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              spi_cs_n,
  output logic              spi_clk,
  output logic              spi_mosi,
  output logic              spi_mosi_oe,
  input  logic [3:0]        spi_miso
);

  localparam int SH_W  = ADDR_W + 8;
  localparam int NIB   = WORD_W / 4;
  localparam int CNT_W = $clog2(SH_W + DUMMY_SCK + 1);
  localparam int NIB_W = $clog2(NIB + 1);
  localparam logic [CNT_W-1:0] LAST_CMD   = CNT_W'(7);
  localparam logic [CNT_W-1:0] LAST_ADDR  = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] LAST_DUMMY = CNT_W'(DUMMY_SCK - 1);
  localparam logic [NIB_W-1:0] LAST_NIB   = NIB_W'(NIB - 1);

`ifdef QSPI_STREAM_CTRL_FLASH_RESET_EN
  localparam state_e           RST_STATE = RST_EN;
  localparam logic [SH_W-1:0]  RST_SH    = {CMD_RST_EN, {ADDR_W{1'b0}}};
`else
  localparam state_e           RST_STATE = IDLE;
  localparam logic [SH_W-1:0]  RST_SH    = '0;
`endif

  state_e            state_q, state_d;
  logic              phase_q, phase_d;
  logic              cs_n_q, cs_n_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic              oe_q, oe_d;
  logic              stopping_q, stopping_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NIB_W-1:0]  nib_q, nib_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [1:0]        gap_q, gap_d;
  logic              fifo_push, fifo_clr, fifo_full, period_end;
  logic [1:0]        fifo_count;

  assign fifo_full = fifo_count == 2'd2;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cs_n_d     = cs_n_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    oe_d       = oe_q;
    stopping_d = stopping_q;
    cnt_d      = cnt_q;
    nib_d      = nib_q;
    sh_d       = sh_q;
    word_d     = word_q;
    gap_d      = gap_q;
    fifo_push  = 1'b0;
    fifo_clr   = 1'b0;
    period_end = 1'b0;

    if (stopping_q || (stop && (state_q != IDLE) && !phase_q)) begin
      state_d    = IDLE;
      phase_d    = 1'b0;
      cs_n_d     = 1'b1;
      sck_d      = 1'b0;
      mosi_d     = 1'b0;
      oe_d       = 1'b1;
      stopping_d = 1'b0;
      nib_d      = '0;
      fifo_clr   = 1'b1;
    end else if (stop && (state_q != IDLE)) begin
      // Finish the high half of SCK; the nibble it carried is dropped.
      sck_d      = 1'b0;
      phase_d    = 1'b0;
      stopping_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = CMD;
            sh_d    = {CMD_QUAD_READ, start_addr};
            cnt_d   = '0;
            gap_d   = 2'd0;
            phase_d = 1'b0;
          end
        end
        CMD, ADDR, DUMMY, RST_EN, RST: begin
          if (cs_n_q) begin
            if (gap_q != 2'd0) begin
              gap_d = gap_q - 2'd1;
            end else begin
              cs_n_d = 1'b0;
              mosi_d = sh_q[SH_W-1];
            end
          end else if (!phase_q) begin
            sck_d   = 1'b1;
            phase_d = 1'b1;
          end else begin
            sck_d      = 1'b0;
            phase_d    = 1'b0;
            period_end = 1'b1;
            cnt_d      = cnt_q + CNT_W'(1);
            sh_d       = {sh_q[SH_W-2:0], 1'b0};
            mosi_d     = sh_q[SH_W-2];
          end
          if (period_end) begin
            case (state_q)
              CMD: if (cnt_q == LAST_CMD) begin
                state_d = ADDR;
                cnt_d   = '0;
              end
              ADDR: if (cnt_q == LAST_ADDR) begin
                state_d = DUMMY;
                cnt_d   = '0;
                oe_d    = 1'b0;
                mosi_d  = 1'b0;
              end
              DUMMY: if (cnt_q == LAST_DUMMY) begin
                state_d = DATA;
                cnt_d   = '0;
                nib_d   = '0;
              end
              RST_EN: if (cnt_q == LAST_CMD) begin
                state_d = RST;
                cnt_d   = '0;
                cs_n_d  = 1'b1;
                gap_d   = FLASH_RST_GAP - 2'd1;
                sh_d    = {CMD_RST, {ADDR_W{1'b0}}};
                mosi_d  = 1'b0;
              end
              RST: if (cnt_q == LAST_CMD) begin
                state_d = IDLE;
                cnt_d   = '0;
                cs_n_d  = 1'b1;
                mosi_d  = 1'b0;
              end
              default: ;
            endcase
          end
        end
        DATA: begin
          if (!phase_q) begin
            // Only a word boundary may stall, so a started word always has a slot.
            if ((nib_q == '0) && fifo_full) begin
              state_d = STALL;
            end else begin
              sck_d   = 1'b1;
              phase_d = 1'b1;
            end
          end else begin
            sck_d   = 1'b0;
            phase_d = 1'b0;
            word_d  = {word_q[WORD_W-5:0], spi_miso};
            if (nib_q == LAST_NIB) begin
              nib_d     = '0;
              fifo_push = 1'b1;
            end else begin
              nib_d = nib_q + NIB_W'(1);
            end
          end
        end
        STALL: begin
          if (!fifo_full) state_d = DATA;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RST_STATE;
      phase_q    <= 1'b0;
      cs_n_q     <= 1'b1;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      oe_q       <= 1'b1;
      stopping_q <= 1'b0;
      cnt_q      <= '0;
      nib_q      <= '0;
      sh_q       <= RST_SH;
      word_q     <= '0;
      gap_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cs_n_q     <= cs_n_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      oe_q       <= oe_d;
      stopping_q <= stopping_d;
      cnt_q      <= cnt_d;
      nib_q      <= nib_d;
      sh_q       <= sh_d;
      word_q     <= word_d;
      gap_q      <= gap_d;
    end
  end

  word_fifo2 #(.WORD_W(WORD_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (fifo_clr),
    .push  (fifo_push),
    .din   (word_d),
    .pop   (data_ready),
    .dout  (data_out),
    .valid (data_valid),
    .count (fifo_count)
  );

  assign busy        = state_q != IDLE;
  assign spi_cs_n    = cs_n_q;
  assign spi_clk     = sck_q;
  assign spi_mosi    = mosi_q;
  assign spi_mosi_oe = oe_q;

endmodule
